// File: rtl/cpu_pkg.sv
// Shared core definitions: default widths, register/tag types and busy-bit constants.
package cpu_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned TAG_W_DEF = 4;
    localparam int unsigned NREG_DEF  = 32;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
    typedef logic [TAG_W_DEF-1:0]        tag_t;

    localparam reg_addr_t REG_ZERO = '0;

    localparam logic Busy = 1'b1;
    localparam logic Free = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// Single rename-table lookup: invalid/x0 masking plus optional commit bypass.
// Bypass is compiled in when REGFILE_COMMIT_BYPASS_EN is defined.
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned AW    = 5
) (
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [XLEN-1:0]  reg_data_i,
    input  logic             reg_busy_i,
    input  logic [TAG_W-1:0] reg_tag_i,
    input  logic             cm_valid_i,
    input  logic [TAG_W-1:0] cm_tag_i,
    input  logic [XLEN-1:0]  cm_data_i,
    output logic [XLEN-1:0]  data_o,
    output logic             busy_o,
    output logic [TAG_W-1:0] tag_o
);

`ifndef REGFILE_COMMIT_BYPASS_EN
    logic unused_cm;
    assign unused_cm = ^{cm_valid_i, cm_tag_i, cm_data_i};
`endif

    always_comb begin
        data_o = '0;
        busy_o = Free;
        tag_o  = '0;
        if (rst_n && valid_i && (addr_i != AW'(REG_ZERO))) begin
`ifdef REGFILE_COMMIT_BYPASS_EN
            // Producer is retiring this very cycle: hand out its result directly.
            if ((reg_busy_i == Busy) && cm_valid_i && (reg_tag_i == cm_tag_i)) begin
                data_o = cm_data_i;
            end else begin
                data_o = reg_data_i;
                busy_o = reg_busy_i;
                tag_o  = reg_tag_i;
            end
`else
            data_o = reg_data_i;
            busy_o = reg_busy_i;
            tag_o  = reg_tag_i;
`endif
        end
    end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file with rename (tag/busy) table, ROB commit port and flush.
// Optional same-cycle commit bypass on reads: REGFILE_COMMIT_BYPASS_EN.
module regfile_rat
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned NUM_RD = 2,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic [NUM_RD-1:0]       rd_valid_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]       rd_busy_o,
    output logic [NUM_RD*TAG_W-1:0] rd_tag_o,
    input  logic                    rn_valid_i,
    input  logic [AW-1:0]           rn_addr_i,
    input  logic [TAG_W-1:0]        rn_tag_i,
    input  logic                    cm_valid_i,
    input  logic [AW-1:0]           cm_addr_i,
    input  logic [TAG_W-1:0]        cm_tag_i,
    input  logic [XLEN-1:0]         cm_data_i
);

    logic [XLEN-1:0]  data_q [NREG];
    logic [XLEN-1:0]  data_d [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic             busy_q [NREG];
    logic             busy_d [NREG];

    // Rename is applied after the commit so it overrides the busy clear on a same-address collision.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy) begin
            if (cm_valid_i && (cm_addr_i != AW'(REG_ZERO))) begin
                data_d[cm_addr_i] = cm_data_i;
                if (tag_q[cm_addr_i] == cm_tag_i) begin
                    busy_d[cm_addr_i] = Free;
                end
            end
            if (clear) begin
                for (int unsigned r = 0; r < NREG; r++) begin
                    busy_d[r] = Free;
                end
            end else if (rn_valid_i && (rn_addr_i != AW'(REG_ZERO))) begin
                tag_d[rn_addr_i]  = rn_tag_i;
                busy_d[rn_addr_i] = Busy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
                busy_q[r] <= Free;
            end
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr_i[p*AW +: AW];

        regfile_rd_port #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .AW    (AW)
        ) u_port (
            .rst_n      (rst_n),
            .valid_i    (rd_valid_i[p]),
            .addr_i     (addr),
            .reg_data_i (data_q[addr]),
            .reg_busy_i (busy_q[addr]),
            .reg_tag_i  (tag_q[addr]),
            .cm_valid_i (cm_valid_i),
            .cm_tag_i   (cm_tag_i),
            .cm_data_i  (cm_data_i),
            .data_o     (rd_data_o[p*XLEN +: XLEN]),
            .busy_o     (rd_busy_o[p]),
            .tag_o      (rd_tag_o[p*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_regfile_rat.sv
// Self-checking bench for regfile_rat: directed scenarios plus random traffic against an array model.
module tb_regfile_rat;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned AW     = 5;

    logic                    clk = 1'b0;
    logic                    rst_n, rdy, clear;
    logic [NUM_RD-1:0]       rd_valid_i;
    logic [NUM_RD*AW-1:0]    rd_addr_i;
    logic [NUM_RD*XLEN-1:0]  rd_data_o;
    logic [NUM_RD-1:0]       rd_busy_o;
    logic [NUM_RD*TAG_W-1:0] rd_tag_o;
    logic                    rn_valid_i;
    logic [AW-1:0]           rn_addr_i;
    logic [TAG_W-1:0]        rn_tag_i;
    logic                    cm_valid_i;
    logic [AW-1:0]           cm_addr_i;
    logic [TAG_W-1:0]        cm_tag_i;
    logic [XLEN-1:0]         cm_data_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [XLEN-1:0]  m_data [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];
    bit               m_busy [NREG];

    always #5 clk = ~clk;

    regfile_rat #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .TAG_W  (TAG_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .clear      (clear),
        .rd_valid_i (rd_valid_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .rd_tag_o   (rd_tag_o),
        .rn_valid_i (rn_valid_i),
        .rn_addr_i  (rn_addr_i),
        .rn_tag_i   (rn_tag_i),
        .cm_valid_i (cm_valid_i),
        .cm_addr_i  (cm_addr_i),
        .cm_tag_i   (cm_tag_i),
        .cm_data_i  (cm_data_i)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; clear = 1'b0;
        rn_valid_i = 1'b0; rn_addr_i = '0; rn_tag_i = '0;
        cm_valid_i = 1'b0; cm_addr_i = '0; cm_tag_i = '0; cm_data_i = '0;
    endtask

    task automatic set_rd(input int p, input logic v, input logic [AW-1:0] a);
        rd_valid_i[p] = v;
        rd_addr_i[p*AW +: AW] = a;
    endtask

    // Expected read of port p from the model and the current (pre-edge) inputs.
    task automatic check_reads();
        for (int p = 0; p < NUM_RD; p++) begin
            logic [AW-1:0]    a;
            logic [XLEN-1:0]  ed;
            logic             eb;
            logic [TAG_W-1:0] et;
            a = rd_addr_i[p*AW +: AW];
            ed = '0; eb = 1'b0; et = '0;
            if (rd_valid_i[p] && rst_n && a != 0) begin
                ed = m_data[a]; eb = m_busy[a]; et = m_tag[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
                if (m_busy[a] && cm_valid_i && m_tag[a] == cm_tag_i) begin
                    ed = cm_data_i; eb = 1'b0; et = '0;
                end
`endif
            end
            chk($sformatf("p%0d.data", p), rd_data_o[p*XLEN +: XLEN], ed);
            chk($sformatf("p%0d.busy", p), XLEN'(rd_busy_o[p]), XLEN'(eb));
            chk($sformatf("p%0d.tag", p), XLEN'(rd_tag_o[p*TAG_W +: TAG_W]), XLEN'(et));
        end
    endtask

    task automatic model_edge();
        bit cm_hit, rn_ok;
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                m_data[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
            end
        end else if (rdy) begin
            rn_ok  = rn_valid_i && rn_addr_i != 0 && !clear;
            cm_hit = cm_valid_i && cm_addr_i != 0 && m_tag[cm_addr_i] == cm_tag_i;
            if (cm_valid_i && cm_addr_i != 0) m_data[cm_addr_i] = cm_data_i;
            if (clear) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            end else begin
                if (cm_hit && !(rn_ok && rn_addr_i == cm_addr_i)) m_busy[cm_addr_i] = 1'b0;
                if (rn_ok) begin
                    m_tag[rn_addr_i] = rn_tag_i;
                    m_busy[rn_addr_i] = 1'b1;
                end
            end
        end
    endtask

    // Check reads mid-cycle, then advance one edge and update the model.
    task automatic step();
        @(negedge clk);
        check_reads();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic expect_reg(input string tag, input logic [AW-1:0] a,
                              input logic [XLEN-1:0] d, input logic b, input logic [TAG_W-1:0] t);
        set_rd(0, 1'b1, a);
        #1;
        chk({tag, ".data"}, rd_data_o[XLEN-1:0], d);
        chk({tag, ".busy"}, XLEN'(rd_busy_o[0]), XLEN'(b));
        chk({tag, ".tag"},  XLEN'(rd_tag_o[TAG_W-1:0]), XLEN'(t));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        rd_valid_i = '1;
        rd_addr_i = '0;
        for (int p = 0; p < NUM_RD; p++) set_rd(p, 1'b1, 5'd5);
        for (int r = 0; r < NREG; r++) begin
            m_data[r] = 'x; m_tag[r] = 'x; m_busy[r] = 1'bx;
        end
        #1;
        step();
        rst_n = 1'b1;
        step();
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("rst.p%0d.data", p), rd_data_o[p*XLEN +: XLEN], '0);
            chk($sformatf("rst.p%0d.busy", p), XLEN'(rd_busy_o[p]), '0);
        end

        rn_valid_i = 1'b1; rn_addr_i = 5'd5; rn_tag_i = 4'd3;
        step(); idle();
        expect_reg("rn5", 5'd5, 32'h0, 1'b1, 4'd3);
        cm_valid_i = 1'b1; cm_addr_i = 5'd5; cm_tag_i = 4'd3; cm_data_i = 32'hDEADBEEF;
        step(); idle();
        expect_reg("cm5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd3);

        rn_valid_i = 1'b1; rn_addr_i = 5'd7; rn_tag_i = 4'd2; step();
        rn_tag_i = 4'd6; step(); idle();
        cm_valid_i = 1'b1; cm_addr_i = 5'd7; cm_tag_i = 4'd2; cm_data_i = 32'h11;
        step(); idle();
        expect_reg("stale7", 5'd7, 32'h11, 1'b1, 4'd6);

        rn_valid_i = 1'b1; rn_addr_i = 5'd9; rn_tag_i = 4'd1; step(); idle();
        rn_valid_i = 1'b1; rn_addr_i = 5'd9; rn_tag_i = 4'd4;
        cm_valid_i = 1'b1; cm_addr_i = 5'd9; cm_tag_i = 4'd1; cm_data_i = 32'hA5A5_0009;
        step(); idle();
        expect_reg("same9", 5'd9, 32'hA5A5_0009, 1'b1, 4'd4);

        rn_valid_i = 1'b1; rn_addr_i = 5'd0; rn_tag_i = 4'd7;
        cm_valid_i = 1'b1; cm_addr_i = 5'd0; cm_tag_i = 4'd0; cm_data_i = 32'hFFFF_FFFF;
        step(); idle();
        expect_reg("x0", 5'd0, 32'h0, 1'b0, 4'd0);

        rn_valid_i = 1'b1; rn_addr_i = 5'd3; rn_tag_i = 4'd8; step();
        rn_addr_i = 5'd4; rn_tag_i = 4'd9; step(); idle();
        clear = 1'b1; rn_valid_i = 1'b1; rn_addr_i = 5'd12; rn_tag_i = 4'd10;
        cm_valid_i = 1'b1; cm_addr_i = 5'd3; cm_tag_i = 4'd0; cm_data_i = 32'h55;
        step(); idle();
        expect_reg("clr3", 5'd3, 32'h55, 1'b0, 4'd8);
        expect_reg("clr4", 5'd4, 32'h0, 1'b0, 4'd9);
        expect_reg("clr12", 5'd12, 32'h0, 1'b0, 4'd0);

        rdy = 1'b0; rn_valid_i = 1'b1; rn_addr_i = 5'd10; rn_tag_i = 4'd11;
        step(); idle();
        expect_reg("hold10", 5'd10, 32'h0, 1'b0, 4'd0);

        rn_valid_i = 1'b1; rn_addr_i = 5'd6; rn_tag_i = 4'd5; step(); idle();
        cm_valid_i = 1'b1; cm_addr_i = 5'd6; cm_tag_i = 4'd5; cm_data_i = 32'h1234;
        set_rd(1, 1'b1, 5'd6);
        #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        chk("byp.data", rd_data_o[XLEN +: XLEN], 32'h1234);
        chk("byp.busy", XLEN'(rd_busy_o[1]), '0);
        chk("byp.tag",  XLEN'(rd_tag_o[TAG_W +: TAG_W]), '0);
`else
        chk("nobyp.data", rd_data_o[XLEN +: XLEN], 32'h0);
        chk("nobyp.busy", XLEN'(rd_busy_o[1]), XLEN'(1));
        chk("nobyp.tag",  XLEN'(rd_tag_o[TAG_W +: TAG_W]), XLEN'(5));
`endif
        step(); idle();
        expect_reg("post6", 5'd6, 32'h1234, 1'b0, 4'd5);

        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            rdy        = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 19) == 0);
            rn_valid_i = $urandom_range(0, 1) == 1;
            rn_addr_i  = AW'($urandom_range(0, 7));
            rn_tag_i   = TAG_W'($urandom);
            cm_valid_i = $urandom_range(0, 1) == 1;
            cm_addr_i  = AW'($urandom_range(0, 7));
            cm_tag_i   = ($urandom_range(0, 1) == 1) ? m_tag[cm_addr_i] : TAG_W'($urandom);
            cm_data_i  = $urandom;
            for (int p = 0; p < NUM_RD; p++)
                set_rd(p, $urandom_range(0, 7) != 0, AW'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
